andromeda_pixel_tx: RTL and testbench
=====================================

Name: andromeda_pixel_tx

Overview:
Transmit-side counterpart of the Andromeda capture path. Reads a stored 720x480 12-bit-per-channel RGB frame from an external synchronous frame-buffer RAM in raster order. Drives it out as a parallel pixel stream with NTSC-style raster timing: 858 clocks/line, 525 lines/frame at 13.5 MHz. Sits between the frame buffer and the sensor-side/monitor output pins, so captured frames can be replayed for loopback test and preview.

Parameters:
IMAGE_WIDTH, 720, active pixels per line
IMAGE_HEIGHT, 480, active lines per frame
H_BLANK, 138, blanking clocks per line (line total = IMAGE_WIDTH+H_BLANK)
V_BLANK, 45, blanking lines per frame (frame total = IMAGE_HEIGHT+V_BLANK)
HSYNC_LEN, 62, hsync high clocks, starting at first blanking clock of each line
VSYNC_LEN, 6, vsync high lines, starting at first blanking line
ADDR_WIDTH, 19, frame-buffer address width (must hold IMAGE_WIDTH*IMAGE_HEIGHT-1)

Ports:
clock  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  level; high starts/continues transmission, low stops at the next frame boundary
mem_rd_en  out  1  frame-buffer read strobe
mem_rd_addr  out  ADDR_WIDTH  pixel address, y*IMAGE_WIDTH+x
mem_rd_data  in  36  {red[35:24], green[23:12], blue[11:0]}, valid the cycle after mem_rd_en
red_data_out  out  12  red pixel
green_data_out  out  12  green pixel
blue_data_out  out  12  blue pixel
pixel_valid  out  1  RGB outputs carry an active pixel
line_start  out  1  one-clock pulse with the first active pixel of each line
frame_start  out  1  one-clock pulse with pixel (0,0)
hsync  out  1  horizontal sync, active-high
vsync  out  1  vertical sync, active-high
busy  out  1  high from leaving IDLE until the frame-end pipeline drains

Behaviour:
- Reset: all outputs 0; state IDLE; x, y, address counters 0. Reset mid-frame aborts immediately; no partial-frame continuation.
- States:
  - IDLE: counters held at 0. enable=1 moves to RUN on the next edge.
  - RUN: x counts 0..IMAGE_WIDTH+H_BLANK-1, then wraps to 0 and y increments. y counts 0..IMAGE_HEIGHT+V_BLANK-1, then wraps to 0.
  - At the last clock of a frame (x=857, y=524 with defaults): enable=1 stays in RUN with x=y=0. enable=0 goes to DRAIN.
  - DRAIN: 2 clocks, then IDLE. Mid-frame enable changes are ignored.
- Reads: mem_rd_en = RUN and x<IMAGE_WIDTH and y<IMAGE_HEIGHT.
  - Address is maintained incrementally, with no multiplier. It is 0 at frame start and +1 per read.
  - Address holds through blanking and returns to 0 at frame wrap. The last address is 345599.
- Pipeline, with read issued in cycle t:
  - Edge ending t: stage-1 registers capture active, first-of-line, first-of-frame, hsync and vsync.
  - mem_rd_data is valid in cycle t+1.
  - Edge ending t+1: output registers load RGB and the stage-1 flags.
  - Outputs are therefore valid in cycle t+2. Fixed latency is 2 clocks from mem_rd_en to pixel_valid.
  - hsync and vsync share the same 2-stage delay, so all outputs stay mutually aligned.
- Blanking: pixel_valid=0 and RGB outputs forced to 0.
- Sync timing, in undelayed counter terms:
  - hsync=1 for IMAGE_WIDTH <= x < IMAGE_WIDTH+HSYNC_LEN, on every line including blanking lines.
  - vsync=1 for IMAGE_HEIGHT <= y < IMAGE_HEIGHT+VSYNC_LEN, for the whole line.
- line_start=1 with x=0 and y<IMAGE_HEIGHT. frame_start=1 with x=0 and y=0. Both are delayed 2 clocks like the pixel data.
- busy=1 in RUN and DRAIN; 0 in IDLE.

Test Plan:
- Reset with enable=0 -> all outputs 0, mem_rd_en never asserts over 1000 clocks.
- Reset released, enable=1 at cycle 0:
  - Cycle 1: RUN, mem_rd_en=1, addr=0.
  - RAM returns 0x123_456_789 for addr 0; 2 clocks after the first mem_rd_en: pixel_valid=1, frame_start=1, line_start=1, R=0x123, G=0x456, B=0x789.
- Line timing -> pixel_valid stays high 720 consecutive clocks, then 138 low.
  - hsync high exactly 62 clocks, starting the clock after the last valid pixel.
  - Second line first address is 720.
- Full frame -> exactly 345600 reads; addresses 0..345599 each read once.
  - vsync high 6x858 clocks.
  - frame_start recurs every 450450 clocks.
  - Address returns to 0 at the next frame.
- enable dropped at line 100 -> frame completes all 525 lines; busy falls 2 clocks after the frame's final clock; no further reads.
- reset asserted at pixel (300,200) -> next clock all outputs 0 and IDLE.
  - With enable high, reset release restarts at addr 0 with frame_start.

Source files
------------

// File: rtl/andromeda_pixel_tx.sv
// andromeda_pixel_tx: replays a stored RGB frame from a synchronous frame
// buffer as a parallel pixel stream with NTSC-style raster timing.
module andromeda_pixel_tx #(
  parameter int unsigned IMAGE_WIDTH  = 720,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned H_BLANK      = 138,
  parameter int unsigned V_BLANK      = 45,
  parameter int unsigned HSYNC_LEN    = 62,
  parameter int unsigned VSYNC_LEN    = 6,
  parameter int unsigned ADDR_WIDTH   = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [35:0]           mem_rd_data,
  output logic [11:0]           red_data_out,
  output logic [11:0]           green_data_out,
  output logic [11:0]           blue_data_out,
  output logic                  pixel_valid,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  busy
);

  localparam int unsigned LINE_TOTAL  = IMAGE_WIDTH + H_BLANK;
  localparam int unsigned FRAME_LINES = IMAGE_HEIGHT + V_BLANK;
  localparam int unsigned XW = $clog2(LINE_TOTAL);
  localparam int unsigned YW = $clog2(FRAME_LINES);

  localparam logic [XW-1:0] X_ACT    = XW'(IMAGE_WIDTH);
  localparam logic [XW-1:0] X_LAST   = XW'(LINE_TOTAL - 1);
  localparam logic [XW-1:0] X_HS_END = XW'(IMAGE_WIDTH + HSYNC_LEN);
  localparam logic [YW-1:0] Y_ACT    = YW'(IMAGE_HEIGHT);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_LINES - 1);
  localparam logic [YW-1:0] Y_VS_END = YW'(IMAGE_HEIGHT + VSYNC_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  drain_q, drain_d;

  logic run, active, line_end, frame_end;
  logic hs_now, vs_now, ls_now, fs_now;

  logic s1_active, s1_ls, s1_fs, s1_hs, s1_vs;

  // Next-state, raster counters and incremental read address
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    drain_d   = 1'b0;
    run       = (state_q == RUN);
    active    = run && (x_q < X_ACT) && (y_q < Y_ACT);
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);
    hs_now    = run && (x_q >= X_ACT) && (x_q < X_HS_END);
    vs_now    = run && (y_q >= Y_ACT) && (y_q < Y_VS_END);
    ls_now    = active && (x_q == '0);
    fs_now    = run && (x_q == '0) && (y_q == '0);

    case (state_q)
      IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (active) addr_d = addr_q + 1'b1;
        if (line_end) begin
          x_d = '0;
          if (frame_end) begin
            y_d    = '0;
            addr_d = '0;
            if (!enable) state_d = DRAIN;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      DRAIN: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        // drain_q marks the second DRAIN clock
        if (drain_q) state_d = IDLE;
        else         drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en   = active;
  assign mem_rd_addr = addr_q;
  assign busy        = (state_q != IDLE);

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  // Stage 1: flags captured alongside the read request
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_ls     <= 1'b0;
      s1_fs     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else begin
      s1_active <= active;
      s1_ls     <= ls_now;
      s1_fs     <= fs_now;
      s1_hs     <= hs_now;
      s1_vs     <= vs_now;
    end
  end

  // Stage 2: output registers, RGB forced to zero outside active video
  always_ff @(posedge clock) begin
    if (reset) begin
      red_data_out   <= '0;
      green_data_out <= '0;
      blue_data_out  <= '0;
      pixel_valid    <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      hsync          <= 1'b0;
      vsync          <= 1'b0;
    end else begin
      red_data_out   <= s1_active ? mem_rd_data[35:24] : '0;
      green_data_out <= s1_active ? mem_rd_data[23:12] : '0;
      blue_data_out  <= s1_active ? mem_rd_data[11:0]  : '0;
      pixel_valid    <= s1_active;
      line_start     <= s1_ls;
      frame_start    <= s1_fs;
      hsync          <= s1_hs;
      vsync          <= s1_vs;
    end
  end

endmodule

// File: tb/tb_andromeda_pixel_tx.sv
// tb_andromeda_pixel_tx: reduced-geometry bench (8x4 active, 14x7 total)
// with a checkpoint table, a pixel scoreboard and multi-cycle sequences.
module tb_andromeda_pixel_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned HB = 6;
  localparam int unsigned VB = 3;
  localparam int unsigned HS = 3;
  localparam int unsigned VS = 2;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [35:0]   mem_rd_data = '0;
  logic [11:0]   red_data_out, green_data_out, blue_data_out;
  logic          pixel_valid, line_start, frame_start, hsync, vsync, busy;

  int total = 0;
  int bad   = 0;

  andromeda_pixel_tx #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
    .HSYNC_LEN(HS), .VSYNC_LEN(VS), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .red_data_out(red_data_out), .green_data_out(green_data_out),
    .blue_data_out(blue_data_out), .pixel_valid(pixel_valid),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] ram_word(input logic [AW-1:0] a);
    logic [11:0] e;
    e = 12'(a);
    return {12'h123 + e, 12'h456 + e, 12'h789 + e};
  endfunction

  // Synchronous frame-buffer RAM model
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram_word(mem_rd_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: reads push expected pixels, valid outputs pop them
  typedef struct packed {
    logic [35:0] rgb;
    logic        ls;
    logic        fs;
  } pix_t;

  pix_t          sbq[$];
  logic [AW-1:0] exp_addr = '0;

  always @(negedge clk) begin
    pix_t p;
    if (pixel_valid) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        p = sbq.pop_front();
        chk("sb_rgb", {red_data_out, green_data_out, blue_data_out}, p.rgb);
        chk("sb_line_start", line_start, p.ls);
        chk("sb_frame_start", frame_start, p.fs);
      end
    end else begin
      chk("blank_rgb", {red_data_out, green_data_out, blue_data_out}, 36'd0);
      chk("blank_flags", {line_start, frame_start}, 2'b00);
    end
    if (reset) begin
      sbq.delete();
      exp_addr = '0;
    end else if (mem_rd_en) begin
      chk("rd_addr", mem_rd_addr, exp_addr);
      p.rgb = ram_word(exp_addr);
      p.ls  = (int'(exp_addr) % W) == 0;
      p.fs  = (exp_addr == '0);
      sbq.push_back(p);
      exp_addr = (int'(exp_addr) == W * H - 1) ? '0 : exp_addr + 1'b1;
    end
  end

  // Checkpoints after enable rises; n counts clocks, RUN begins at n=1
  typedef struct {
    int unsigned   n;
    logic          rd;
    logic [AW-1:0] addr;
    logic          pv, hs, vs, ls, fs;
    logic [35:0]   rgb;
  } vec_t;

  localparam int unsigned NV = 16;
  vec_t vecs[NV];

  task automatic wait_fs(output logic found);
    found = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rd_seen, pv_n, vs_n, hs_n, rd_n, idx;
    logic found;

    vecs[0]  = '{0,   0, 0,  0, 0, 0, 0, 0, 36'h0};
    vecs[1]  = '{1,   1, 0,  0, 0, 0, 0, 0, 36'h0};
    vecs[2]  = '{3,   1, 2,  1, 0, 0, 1, 1, 36'h123456789};
    vecs[3]  = '{4,   1, 3,  1, 0, 0, 0, 0, 36'h12445778a};
    vecs[4]  = '{9,   0, 8,  1, 0, 0, 0, 0, 36'h12945c78f};
    vecs[5]  = '{11,  0, 8,  0, 1, 0, 0, 0, 36'h0};
    vecs[6]  = '{13,  0, 8,  0, 1, 0, 0, 0, 36'h0};
    vecs[7]  = '{14,  0, 8,  0, 0, 0, 0, 0, 36'h0};
    vecs[8]  = '{15,  1, 8,  0, 0, 0, 0, 0, 36'h0};
    vecs[9]  = '{17,  1, 10, 1, 0, 0, 1, 0, 36'h12b45e791};
    vecs[10] = '{58,  0, 32, 0, 0, 0, 0, 0, 36'h0};
    vecs[11] = '{59,  0, 32, 0, 0, 1, 0, 0, 36'h0};
    vecs[12] = '{68,  0, 32, 0, 1, 1, 0, 0, 36'h0};
    vecs[13] = '{87,  0, 32, 0, 0, 0, 0, 0, 36'h0};
    vecs[14] = '{99,  1, 0,  0, 0, 0, 0, 0, 36'h0};
    vecs[15] = '{101, 1, 2,  1, 0, 0, 1, 1, 36'h123456789};

    // Reset with enable low: quiet outputs, no reads
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("reset_outputs", {mem_rd_en, red_data_out, green_data_out, blue_data_out,
        pixel_valid, line_start, frame_start, hsync, vsync, busy}, '0);
    rd_seen = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      step();
      @(negedge clk);
      if (mem_rd_en) rd_seen++;
    end
    chk("idle_no_reads", 64'(rd_seen), 64'd0);

    // Checkpoint table across the first frame and into the second
    step();
    enable = 1'b1;
    idx = 0;
    for (int unsigned n = 0; n <= 101; n++) begin
      @(negedge clk);
      if (idx < NV && vecs[idx].n == n) begin
        chk($sformatf("tbl%0d_rd", n), mem_rd_en, vecs[idx].rd);
        chk($sformatf("tbl%0d_addr", n), mem_rd_addr, vecs[idx].addr);
        chk($sformatf("tbl%0d_flags", n), {pixel_valid, hsync, vsync, line_start, frame_start},
            {vecs[idx].pv, vecs[idx].hs, vecs[idx].vs, vecs[idx].ls, vecs[idx].fs});
        chk($sformatf("tbl%0d_rgb", n), {red_data_out, green_data_out, blue_data_out},
            vecs[idx].rgb);
        chk($sformatf("tbl%0d_busy", n), busy, 64'(n != 0));
        idx++;
      end
      step();
    end
    chk("tbl_applied", 64'(idx), 64'(NV));

    // One whole frame: read, sync and frame_start periodicity
    wait_fs(found);
    chk("frame_fs_found", found, 1'b1);
    pv_n = 0; vs_n = 0; hs_n = 0; rd_n = 0;
    for (int unsigned o = 0; o < 98; o++) begin
      if (pixel_valid) pv_n++;
      if (vsync) vs_n++;
      if (hsync) hs_n++;
      if (mem_rd_en) rd_n++;
      step();
      @(negedge clk);
    end
    chk("frame_pixels", 64'(pv_n), 64'(W * H));
    chk("frame_reads", 64'(rd_n), 64'(W * H));
    chk("frame_vsync_clks", 64'(vs_n), 64'(VS * (W + HB)));
    chk("frame_hsync_clks", 64'(hs_n), 64'(HS * (H + VB)));
    chk("frame_start_period", frame_start, 1'b1);

    // Enable dropped mid-frame: frame completes, then drain to idle
    pv_n = 0; rd_n = 0;
    for (int unsigned o = 0; o <= 150; o++) begin
      if (pixel_valid) pv_n++;
      if (o >= 98 && mem_rd_en) rd_n++;
      if (o == 97) chk("drain_busy_hi", busy, 1'b1);
      if (o == 98) chk("drain_busy_lo", busy, 1'b0);
      if (o < 150) begin
        step();
        if (o == 29) enable = 1'b0;
        @(negedge clk);
      end
    end
    chk("drain_pixels", 64'(pv_n), 64'(W * H));
    chk("drain_no_reads", 64'(rd_n), 64'd0);

    // Reset at pixel (3,2) aborts; release restarts at address 0
    step();
    enable = 1'b1;
    wait_fs(found);
    chk("abort_fs_found", found, 1'b1);
    for (int unsigned o = 1; o <= 29; o++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {mem_rd_en, red_data_out, green_data_out, blue_data_out,
        pixel_valid, line_start, frame_start, hsync, vsync, busy}, '0);
    step();
    @(negedge clk);
    chk("restart_rd", mem_rd_en, 1'b1);
    chk("restart_addr", mem_rd_addr, 6'd0);
    step();
    wait_fs(found);
    chk("restart_fs_found", found, 1'b1);
    chk("restart_rgb", {red_data_out, green_data_out, blue_data_out}, 36'h123456789);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
